// File: rtl/aes_spi_pkg.sv
// Shared types and frame layout for the AES command-link SPI master.
// The frame is {loc, addr, key, mode}, sent MSB first.
package aes_spi_pkg;

   localparam int FRAME_BITS = 145;
   localparam int LOC_MSB    = 144;
   localparam int ADDR_MSB   = 136;
   localparam int KEY_MSB    = 128;
   localparam int MODE_BIT   = 0;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      SHIFT,
      WAIT_DONE
   } spi_tx_state_t;

   function automatic logic [FRAME_BITS-1:0] pack_frame(
      input logic [7:0]   loc,
      input logic [7:0]   addr,
      input logic [127:0] key,
      input logic         mode
   );
      logic [FRAME_BITS-1:0] f;
      f = '0;
      f[LOC_MSB  -: 8]   = loc;
      f[ADDR_MSB -: 8]   = addr;
      f[KEY_MSB  -: 128] = key;
      f[MODE_BIT]        = mode;
      return f;
   endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, MSB first, zero-filled from the LSB.
// Load has priority over shift.
module flex_pts_sr #(
   parameter int NUM_BITS = 145
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic                i_shift_enable,
   input  logic [NUM_BITS-1:0] i_parallel_in,
   output logic                o_serial_out
);

   logic [NUM_BITS-1:0] r_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr <= '0;
      end else if (i_load) begin
         r_sr <= i_parallel_in;
      end else if (i_shift_enable) begin
         r_sr <= {r_sr[NUM_BITS-2:0], 1'b0};
      end
   end

   assign o_serial_out = r_sr[NUM_BITS-1];

endmodule

// File: rtl/spi_master_tx.sv
// Master-side serializer for the AES chip command link: one command in,
// one 145-bit frame out on mosi, then wait for the slave's done on miso.
module spi_master_tx
   import aes_spi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [127:0] cmd_key,
   input  logic [7:0]   cmd_addr,
   input  logic [7:0]   cmd_loc,
   input  logic         cmd_mode,
   input  logic         miso,
   output logic         ss,
   output logic         mosi,
   output logic         xfer_done,
   output logic         xfer_err
);

   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   spi_tx_state_t         r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_ss;
   logic                  r_mosi;
   logic                  r_ready;
   logic                  r_done;
   logic                  r_err;

   logic [FRAME_BITS-1:0] w_frame;
   logic                  w_load;
   logic                  w_shift;
   logic                  w_sr_msb;

   assign w_frame = pack_frame(cmd_loc, cmd_addr, cmd_key, cmd_mode);
   assign w_load  = (r_state == IDLE) && cmd_valid && r_ready;
   // The register advances on the ARM->SHIFT edge too, so that the
   // second frame bit is at the MSB when SHIFT begins.
   assign w_shift = !miso && ((r_state == ARM) || (r_state == SHIFT));

   flex_pts_sr #(
      .NUM_BITS(FRAME_BITS)
   ) u_sr (
      .clk            (clk),
      .rst            (rst),
      .i_load         (w_load),
      .i_shift_enable (w_shift),
      .i_parallel_in  (w_frame),
      .o_serial_out   (w_sr_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ss    <= 1'b1;
         r_mosi  <= 1'b0;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (w_load) begin
                  r_ready <= 1'b0;
                  r_state <= ARM;
               end
            end
            ARM: begin
               if (!miso) begin
                  r_ss    <= 1'b0;
                  r_mosi  <= w_sr_msb;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (miso) begin
                  // Slave has cleared its receiver; a partial frame is useless.
                  r_ss    <= 1'b1;
                  r_mosi  <= 1'b0;
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else if (r_cnt == C_LAST_BIT) begin
                  r_ss    <= 1'b1;
                  r_mosi  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= WAIT_DONE;
               end else begin
                  r_mosi <= w_sr_msb;
                  r_cnt  <= r_cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (miso) begin
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (r_cnt == C_TMO_LAST) begin
                  r_err   <= 1'b1;
                  r_ready <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign ss        = r_ss;
   assign mosi      = r_mosi;
   assign xfer_done = r_done;
   assign xfer_err  = r_err;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed plus randomized bench for spi_master_tx; frames are
// predicted from the field layout and compared bit-serially.
module tb_spi_master_tx;

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [127:0] cmd_key;
   logic [7:0]   cmd_addr;
   logic [7:0]   cmd_loc;
   logic         cmd_mode;
   logic         miso;
   logic         ss;
   logic         mosi;
   logic         xfer_done;
   logic         xfer_err;

   int n_tests = 0;
   int n_fail  = 0;

   spi_master_tx dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_key   (cmd_key),
      .cmd_addr  (cmd_addr),
      .cmd_loc   (cmd_loc),
      .cmd_mode  (cmd_mode),
      .miso      (miso),
      .ss        (ss),
      .mosi      (mosi),
      .xfer_done (xfer_done),
      .xfer_err  (xfer_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [144:0] obs,
                        input logic [144:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [144:0] model_frame(input logic [7:0] l,
      input logic [7:0] a, input logic [127:0] k, input logic m);
      return {l, a, k, m};
   endfunction

   task automatic scramble_inputs();
      cmd_loc  = 8'($urandom);
      cmd_addr = 8'($urandom);
      cmd_key  = {$urandom, $urandom, $urandom, $urandom};
      cmd_mode = 1'($urandom);
   endtask

   // Present one command and let the accepting edge occur.
   task automatic issue(input logic [7:0] l, input logic [7:0] a,
                        input logic [127:0] k, input logic m);
      cmd_loc   = l;
      cmd_addr  = a;
      cmd_key   = k;
      cmd_mode  = m;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      scramble_inputs();
   endtask

   // Wait for ss low, then gather bits while ss stays low.
   task automatic capture(input string tag, output logic [144:0] got,
                          output int nlow);
      int w;
      w    = 0;
      got  = '0;
      nlow = 0;
      while (ss !== 1'b0 && w < 20) begin
         tick();
         w++;
      end
      if (w >= 20) check({tag, "_ss_fall_timeout"}, 145'(ss), 145'(0));
      while (ss === 1'b0 && nlow < 200) begin
         got = {got[143:0], mosi};
         nlow++;
         tick();
      end
   endtask

   logic [144:0] exp_f;
   logic [144:0] got_f;
   int           nlow;
   int           c;
   logic         bad;
   logic [7:0]   l_r;
   logic [7:0]   a_r;
   logic [127:0] k_r;
   logic         m_r;

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      miso      = 1'b0;
      scramble_inputs();
      repeat (3) tick();
      check("rst_ss", 145'(ss), 145'(1));
      check("rst_mosi", 145'(mosi), 145'(0));
      check("rst_ready", 145'(cmd_ready), 145'(0));
      check("rst_done", 145'(xfer_done), 145'(0));
      check("rst_err", 145'(xfer_err), 145'(0));
      rst = 1'b0;
      tick();
      check("ready_after_rst", 145'(cmd_ready), 145'(1));

      // Directed frame; cmd_valid held with junk during the transfer
      exp_f = model_frame(8'hA5, 8'h3C,
         128'h000102030405060708090A0B0C0D0E0F, 1'b1);
      issue(8'hA5, 8'h3C, 128'h000102030405060708090A0B0C0D0E0F, 1'b1);
      check("t1_ready_drop", 145'(cmd_ready), 145'(0));
      check("t1_ss_arm", 145'(ss), 145'(1));
      cmd_valid = 1'b1;
      tick();
      check("t1_ss_start", 145'(ss), 145'(0));
      capture("t1", got_f, nlow);
      check("t1_nlow", 145'(nlow), 145'(145));
      check("t1_frame", got_f, exp_f);
      check("t1_loc", 145'(got_f[144:137]), 145'(8'hA5));
      check("t1_addr", 145'(got_f[136:129]), 145'(8'h3C));
      check("t1_mode", 145'(got_f[0]), 145'(1));
      cmd_valid = 1'b0;
      check("t1_mosi_idle", 145'(mosi), 145'(0));
      bad = 1'b0;
      repeat (19) begin
         tick();
         if (xfer_done !== 1'b0 || xfer_err !== 1'b0 || ss !== 1'b1)
            bad = 1'b1;
      end
      check("t1_quiet_wait", 145'(bad), 145'(0));
      miso = 1'b1;
      tick();
      check("t1_done", 145'(xfer_done), 145'(1));
      check("t1_no_err", 145'(xfer_err), 145'(0));
      miso = 1'b0;
      tick();
      check("t1_done_single", 145'(xfer_done), 145'(0));
      check("t1_ready_back", 145'(cmd_ready), 145'(1));

      // miso held high in ARM, then timeout
      l_r = 8'($urandom);
      a_r = 8'($urandom);
      k_r = {$urandom, $urandom, $urandom, $urandom};
      m_r = 1'($urandom);
      exp_f = model_frame(l_r, a_r, k_r, m_r);
      miso = 1'b1;
      issue(l_r, a_r, k_r, m_r);
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (ss !== 1'b1) bad = 1'b1;
      end
      check("t2_ss_held_arm", 145'(bad), 145'(0));
      miso = 1'b0;
      tick();
      check("t2_ss_after_fall", 145'(ss), 145'(0));
      capture("t2", got_f, nlow);
      check("t2_nlow", 145'(nlow), 145'(145));
      check("t2_frame", got_f, exp_f);
      c   = 0;
      bad = 1'b0;
      while (xfer_err !== 1'b1 && c < 5000) begin
         if (xfer_done !== 1'b0) bad = 1'b1;
         tick();
         c++;
      end
      check("t2_timeout_cycles", 145'(c), 145'(4096));
      check("t2_no_done", 145'(bad | xfer_done), 145'(0));
      tick();
      check("t2_err_single", 145'(xfer_err), 145'(0));
      check("t2_ready_back", 145'(cmd_ready), 145'(1));

      // Abort: miso rises at bit 60
      l_r = 8'($urandom);
      a_r = 8'($urandom);
      k_r = {$urandom, $urandom, $urandom, $urandom};
      m_r = 1'($urandom);
      exp_f = model_frame(l_r, a_r, k_r, m_r);
      issue(l_r, a_r, k_r, m_r);
      tick();
      got_f = '0;
      for (int i = 0; i < 60; i++) begin
         got_f = {got_f[143:0], mosi};
         tick();
      end
      check("t3_prefix", 145'(got_f[59:0]), 145'(exp_f[144:85]));
      check("t3_ss_bit60", 145'(ss), 145'(0));
      miso = 1'b1;
      tick();
      check("t3_ss_abort", 145'(ss), 145'(1));
      check("t3_err", 145'(xfer_err), 145'(1));
      check("t3_no_done", 145'(xfer_done), 145'(0));
      check("t3_mosi", 145'(mosi), 145'(0));
      miso = 1'b0;
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (xfer_done !== 1'b0 || xfer_err !== 1'b0) bad = 1'b1;
      end
      check("t3_quiet_after", 145'(bad), 145'(0));
      check("t3_ready", 145'(cmd_ready), 145'(1));

      // Reset mid-frame at bit 100, then a fresh full frame
      issue(8'($urandom), 8'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      tick();
      repeat (100) tick();
      check("t4_ss_bit100", 145'(ss), 145'(0));
      rst = 1'b1;
      tick();
      check("t4_rst_ss", 145'(ss), 145'(1));
      check("t4_rst_mosi", 145'(mosi), 145'(0));
      check("t4_rst_ready", 145'(cmd_ready), 145'(0));
      check("t4_rst_pulses", 145'({xfer_done, xfer_err}), 145'(0));
      rst = 1'b0;
      tick();
      check("t4_ready", 145'(cmd_ready), 145'(1));
      l_r = 8'($urandom);
      a_r = 8'($urandom);
      k_r = {$urandom, $urandom, $urandom, $urandom};
      m_r = 1'($urandom);
      exp_f = model_frame(l_r, a_r, k_r, m_r);
      issue(l_r, a_r, k_r, m_r);
      capture("t4", got_f, nlow);
      check("t4_nlow", 145'(nlow), 145'(145));
      check("t4_frame", got_f, exp_f);
      miso = 1'b1;
      tick();
      check("t4_done", 145'(xfer_done), 145'(1));

      // Randomized back-to-back commands
      for (int it = 0; it < 6; it++) begin
         int r;
         int d;
         r   = int'($urandom_range(0, 5));
         d   = int'($urandom_range(1, 40));
         l_r = 8'($urandom);
         a_r = 8'($urandom);
         k_r = {$urandom, $urandom, $urandom, $urandom};
         m_r = 1'($urandom);
         exp_f = model_frame(l_r, a_r, k_r, m_r);
         check("rnd_ready", 145'(cmd_ready), 145'(1));
         miso = (r > 0);
         issue(l_r, a_r, k_r, m_r);
         check("rnd_ready_drop", 145'(cmd_ready), 145'(0));
         bad = 1'b0;
         for (int j = 0; j < r; j++) begin
            if (ss !== 1'b1) bad = 1'b1;
            tick();
         end
         check("rnd_arm_hold", 145'(bad), 145'(0));
         miso = 1'b0;
         capture("rnd", got_f, nlow);
         check("rnd_nlow", 145'(nlow), 145'(145));
         check("rnd_frame", got_f, exp_f);
         bad = 1'b0;
         for (int j = 0; j < d - 1; j++) begin
            tick();
            if (xfer_done !== 1'b0 || xfer_err !== 1'b0) bad = 1'b1;
         end
         check("rnd_quiet", 145'(bad), 145'(0));
         miso = 1'b1;
         tick();
         check("rnd_done", 145'({xfer_done, xfer_err}), 145'(2'b10));
      end
      miso = 1'b0;
      tick();
      check("end_idle_ss", 145'(ss), 145'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
